// File: rtl/noc_input_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_input_port_pkg
// Description : Shared NoC constants: data/ID widths, port indices, header
//               field layout, buffered flit entry and the XY route function.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_input_port_pkg;

    localparam int Noc_Data_Width = 32;
    localparam int Noc_ID_X_Width = 4;
    localparam int Noc_ID_Y_Width = 4;

    // Header field layout: destination X in the low bits, Y directly above
    localparam int HDR_X_OFFSET = 0;
    localparam int HDR_Y_OFFSET = Noc_ID_X_Width;

    // Output-port indices inside the one-hot route request
    localparam int LOCAL     = 0;
    localparam int NORTH     = 1;
    localparam int SOUTH     = 2;
    localparam int EAST      = 3;
    localparam int WEST      = 4;
    localparam int NUM_PORTS = 5;

    // One buffered flit: framing markers travel alongside the payload
    typedef struct packed {
        logic                      is_header;
        logic                      is_tail;
        logic [Noc_Data_Width-1:0] data;
    } flit_t;

    typedef enum logic [0:0] {
        PKT_IDLE  = 1'b0,
        PKT_INPKT = 1'b1
    } pkt_state_t;

    // Dimension-ordered routing: resolve X completely before moving in Y
    function automatic logic [NUM_PORTS-1:0] xy_route(
        input logic [Noc_ID_X_Width-1:0] dest_x,
        input logic [Noc_ID_Y_Width-1:0] dest_y,
        input logic [Noc_ID_X_Width-1:0] cur_x,
        input logic [Noc_ID_Y_Width-1:0] cur_y
    );
        logic [NUM_PORTS-1:0] port;
        port = '0;
        if (dest_x > cur_x)      port[EAST]  = 1'b1;
        else if (dest_x < cur_x) port[WEST]  = 1'b1;
        else if (dest_y > cur_y) port[NORTH] = 1'b1;
        else if (dest_y < cur_y) port[SOUTH] = 1'b1;
        else                     port[LOCAL] = 1'b1;
        return port;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_flit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : noc_flit_fifo
// Description : DEPTH x WIDTH synchronous FIFO, registered read head (no
//               fall-through), simultaneous push/pop supported.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_flit_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage write; contents are not reset, only the pointers are
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_input_port.sv
`default_nettype none
// ============================================================================
// Module      : noc_input_port
// Description : Router input stage: flit FIFO, XY route decode of header
//               flits, per-packet route hold and sticky framing check.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_input_port
    import noc_input_port_pkg::*;
#(
    parameter logic [Noc_ID_X_Width-1:0] X_ID  = '0,
    parameter logic [Noc_ID_Y_Width-1:0] Y_ID  = '0,
    parameter int                        DEPTH = 4
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [Noc_Data_Width-1:0] in_flit,
    input  logic                      in_is_header,
    input  logic                      in_is_tail,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [Noc_Data_Width-1:0] out_flit,
    output logic                      out_is_header,
    output logic                      out_is_tail,
    output logic [NUM_PORTS-1:0]      out_port,
    output logic                      err_framing
);

    flit_t                  w_in_entry;
    flit_t                  w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_push;
    logic                   w_pop;
    logic [NUM_PORTS-1:0]   w_head_route;
    logic [NUM_PORTS-1:0]   r_route;
    pkt_state_t             r_state;
    logic                   r_err;

    assign w_in_entry = '{is_header: in_is_header, is_tail: in_is_tail, data: in_flit};

    // in_ready depends only on registered occupancy and reset, never on out_ready
    assign in_ready  = !w_full && noc_rst_n;
    assign out_valid = (w_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_ready && !w_empty;

    noc_flit_fifo #(
        .WIDTH ($bits(flit_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (noc_clk),
        .rst_n (noc_rst_n),
        .push  (w_push),
        .wdata (w_in_entry),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_head_route = xy_route(w_head.data[HDR_X_OFFSET +: Noc_ID_X_Width],
                                   w_head.data[HDR_Y_OFFSET +: Noc_ID_Y_Width],
                                   X_ID, Y_ID);

    assign out_flit      = w_head.data;
    assign out_is_header = w_head.is_header;
    assign out_is_tail   = w_head.is_tail;
    // Header decides its own route; body/tail reuse the route latched at header pop
    assign out_port      = w_head.is_header ? w_head_route : r_route;
    assign err_framing   = r_err;

    // Latch the packet route as its header leaves the FIFO
    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            r_route <= NUM_PORTS'(1) << LOCAL;
        end else if (w_pop && w_head.is_header) begin
            r_route <= w_head_route;
        end
    end

    // Push-side packet framing tracker with sticky error flag
    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            r_state <= PKT_IDLE;
            r_err   <= 1'b0;
        end else if (w_push) begin
            if (in_is_header) begin
                // A header always (re)starts a packet, even if one was open
                if (r_state == PKT_INPKT) r_err <= 1'b1;
                r_state <= in_is_tail ? PKT_IDLE : PKT_INPKT;
            end else begin
                // Orphan body/tail outside a packet is flagged but still forwarded
                if (r_state == PKT_IDLE) r_err <= 1'b1;
                if (in_is_tail) r_state <= PKT_IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_noc_input_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_input_port
// Description : Directed self-checking bench for noc_input_port at router
//               (1,1), DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_input_port;
    import noc_input_port_pkg::*;

    localparam int DEPTH = 4;

    logic                      noc_clk = 1'b0;
    logic                      noc_rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic [Noc_Data_Width-1:0] in_flit;
    logic                      in_is_header;
    logic                      in_is_tail;
    logic                      out_valid;
    logic                      out_ready;
    logic [Noc_Data_Width-1:0] out_flit;
    logic                      out_is_header;
    logic                      out_is_tail;
    logic [NUM_PORTS-1:0]      out_port;
    logic                      err_framing;

    int checks = 0;
    int errors = 0;

    always #5 noc_clk = ~noc_clk;

    noc_input_port #(
        .X_ID  (4'd1),
        .Y_ID  (4'd1),
        .DEPTH (DEPTH)
    ) dut (
        .noc_clk       (noc_clk),
        .noc_rst_n     (noc_rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_flit       (in_flit),
        .in_is_header  (in_is_header),
        .in_is_tail    (in_is_tail),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_flit      (out_flit),
        .out_is_header (out_is_header),
        .out_is_tail   (out_is_tail),
        .out_port      (out_port),
        .err_framing   (err_framing)
    );

    task automatic step();
        @(posedge noc_clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [3:0] dx, input logic [3:0] dy,
                                       input logic [23:0] pl);
        return {pl, dy, dx};
    endfunction

    task automatic test_reset();
        noc_rst_n = 1'b0; in_valid = 1'b0; in_flit = '0;
        in_is_header = 1'b0; in_is_tail = 1'b0; out_ready = 1'b0;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (err_framing !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_framing); end
        noc_rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_single();
        logic [31:0] f;
        f = mk(4'd3, 4'd1, 24'hA1A1A1);
        in_valid = 1'b1; in_is_header = 1'b1; in_is_tail = 1'b1; in_flit = f;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b expected 0", out_valid); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (out_port !== 5'b01000) begin errors++; $display("FAIL single_port: got %b expected 01000", out_port); end
        checks++; if (out_flit !== f) begin errors++; $display("FAIL single_flit: got %h expected %h", out_flit, f); end
        checks++; if ({out_is_header, out_is_tail} !== 2'b11) begin errors++; $display("FAIL single_markers: got %b expected 11", {out_is_header, out_is_tail}); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_packet();
        logic [31:0] f [4];
        f[0] = mk(4'd1, 4'd0, 24'hB0B0B0);
        f[1] = 32'h1111_0012;   // body bits that would decode East if misused
        f[2] = 32'h2222_0030;   // would decode West
        f[3] = 32'h3333_0055;   // would decode East
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_is_header = (i == 0); in_is_tail = (i == 3); in_flit = f[i];
            step();
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pkt_full_ready: got %b expected 0", in_ready); end
        step();
        checks++; if (out_flit !== f[0]) begin errors++; $display("FAIL pkt_stall_flit: got %h expected %h", out_flit, f[0]); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_flit !== f[i]) begin errors++; $display("FAIL pkt_flit%0d: got v=%b %h expected v=1 %h", i, out_valid, out_flit, f[i]); end
            checks++; if (out_port !== 5'b00100) begin errors++; $display("FAIL pkt_port%0d: got %b expected 00100", i, out_port); end
            checks++; if (out_is_tail !== (i == 3)) begin errors++; $display("FAIL pkt_tail%0d: got %b expected %b", i, out_is_tail, (i == 3)); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pkt_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] g [6];
        logic        exp_rdy;
        g[0] = mk(4'd1, 4'd2, 24'hC0C0C0);
        g[1] = 32'h4444_0007;
        g[2] = 32'h5555_0070;
        g[3] = 32'h6666_0000;
        g[4] = mk(4'd2, 4'd2, 24'hC4C4C4);
        g[5] = mk(4'd0, 4'd0, 24'hC5C5C5);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_is_header = (i == 0) || (i >= 4); in_is_tail = (i >= 3); in_flit = g[i];
            exp_rdy = (i < 4);
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL bp_ready%0d: got %b expected %b", i, in_ready, exp_rdy); end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_flit !== g[i]) begin errors++; $display("FAIL bp_flit%0d: got v=%b %h expected v=1 %h", i, out_valid, out_flit, g[i]); end
            checks++; if (out_port !== 5'b00010) begin errors++; $display("FAIL bp_port%0d: got %b expected 00010", i, out_port); end
            step();
            if (i == 0) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", in_ready); end
            end
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_extra: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] h [4];
        logic [4:0]  p [4];
        h[0] = mk(4'd0, 4'd1, 24'hD0D0D0); p[0] = 5'b10000;
        h[1] = 32'h7777_0003;              p[1] = 5'b10000;
        h[2] = mk(4'd1, 4'd1, 24'hD2D2D2); p[2] = 5'b00001;
        h[3] = 32'h8888_0009;              p[3] = 5'b00001;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 4);
            if (c < 4) begin
                in_flit = h[c]; in_is_header = (c == 0) || (c == 2); in_is_tail = (c == 1) || (c == 3);
            end
            if (c >= 1) begin
                checks++; if (out_valid !== 1'b1 || out_flit !== h[c-1]) begin errors++; $display("FAIL b2b_flit%0d: got v=%b %h expected v=1 %h", c - 1, out_valid, out_flit, h[c-1]); end
                checks++; if (out_port !== p[c-1]) begin errors++; $display("FAIL b2b_port%0d: got %b expected %b", c - 1, out_port, p[c-1]); end
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
        checks++; if (err_framing !== 1'b0) begin errors++; $display("FAIL b2b_no_err: got %b expected 0", err_framing); end
    endtask

    task automatic test_framing();
        logic [31:0] f;
        f = 32'hDEAD_0021;
        in_valid = 1'b1; in_is_header = 1'b0; in_is_tail = 1'b0; in_flit = f;
        step();
        in_valid = 1'b0;
        checks++; if (err_framing !== 1'b1) begin errors++; $display("FAIL frm_err_set: got %b expected 1", err_framing); end
        checks++; if (out_valid !== 1'b1 || out_flit !== f) begin errors++; $display("FAIL frm_forward: got v=%b %h expected v=1 %h", out_valid, out_flit, f); end
        checks++; if (out_port !== 5'b00001) begin errors++; $display("FAIL frm_port: got %b expected 00001", out_port); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        checks++; if (err_framing !== 1'b1) begin errors++; $display("FAIL frm_sticky: got %b expected 1", err_framing); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frm_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_midpacket();
        out_ready = 1'b0;
        in_valid = 1'b1; in_is_header = 1'b1; in_is_tail = 1'b0; in_flit = mk(4'd0, 4'd0, 24'hE0E0E0);
        step();
        in_is_header = 1'b0; in_flit = 32'h9999_0001;
        step();
        in_valid = 1'b0;
        noc_rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready_low: got %b expected 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        checks++; if (err_framing !== 1'b0) begin errors++; $display("FAIL rst_mid_err_clear: got %b expected 0", err_framing); end
        noc_rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready_high: got %b expected 1", in_ready); end
        out_ready = 1'b1;
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_stale: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_packet();
        test_backpressure();
        test_back_to_back();
        test_framing();
        test_reset_midpacket();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_input_port.md
# noc_input_port

Router input stage that consumes the flit stream a local test node or neighbouring router produces on its sender_* handshake. It buffers flits in a small FIFO and decodes the destination from each header flit with dimension-ordered XY routing. It presents every flit with a one-hot output-port request that stays fixed for the whole packet. It sits between a node's sender interface and the router's switch allocator/crossbar.

## Interface
- X_ID, 0, router X coordinate (width Noc_ID_X_Width)
- Y_ID, 0, router Y coordinate (width Noc_ID_Y_Width)
- DEPTH, 4, FIFO depth in flits; power of two, ≥2
- noc_clk  in  1  clock; everything sampled on rising edge
- noc_rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  upstream flit valid
- in_ready  out  1  FIFO can accept a flit
- in_flit  in  Noc_Data_Width  flit payload
- in_is_header  in  1  flit is first of packet
- in_is_tail  in  1  flit is last of packet (header+tail = single-flit packet)
- out_valid  out  1  head flit available
- out_ready  in  1  downstream consumes head flit
- out_flit  out  Noc_Data_Width  head flit payload
- out_is_header  out  1  head flit header marker
- out_is_tail  out  1  head flit tail marker
- out_port  out  5  one-hot route request {West,East,South,North,Local} = bits [4:0]; meaningful only while out_valid
- err_framing  out  1  sticky framing-error flag

## Operation
- Header format: dest X = flit[Noc_ID_X_Width-1:0]; dest Y = flit[Noc_ID_X_Width +: Noc_ID_Y_Width]. Both fields are unsigned.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready. Push and pop may happen in the same cycle.
- in_ready = (count < DEPTH) && noc_rst_n. It is driven from the registered count, with no combinational path from out_ready.
- out_valid = (count != 0). The head flit and its markers are driven directly from FIFO storage.
- XY route function:
  - dest X > X_ID → East (bit 3).
  - dest X < X_ID → West (bit 4).
  - Otherwise dest Y > Y_ID → North (bit 1).
  - dest Y < Y_ID → South (bit 2).
  - Otherwise Local (bit 0).
- out_port source:
  - Head is a header: out_port is computed combinationally from the head flit.
  - Head is not a header: out_port = route_reg.
  - route_reg loads the computed value on each header pop. It holds until the next header pop.
- Packet state machine, on the push side with two states:
  - IDLE, header push → INPKT.
  - INPKT, tail push → IDLE.
  - Header+tail push from IDLE stays IDLE.
- Framing errors:
  - A header pushed in INPKT, or a non-header pushed in IDLE, sets err_framing.
  - The offending flit is still stored and forwarded unchanged.
  - A header pushed in INPKT restarts the packet, so the state stays INPKT unless that flit is also a tail.
- err_framing clears only on reset.

## Timing
- Reset (noc_rst_n low at an edge):
  - count, read pointer, write pointer and route_reg (5'b00001) are cleared; state = IDLE.
  - Outputs: out_valid=0, err_framing=0, in_ready=0 during reset, 1 in the first cycle after release.
  - FIFO contents are don't-care.
  - Reset mid-packet discards all buffered flits. No partial packet is emitted afterwards.
- Latency: a flit pushed at edge N is visible on out_* after edge N (1 cycle, no fall-through bypass).
- Full (count==DEPTH): in_ready=0. A pop that cycle raises in_ready the next cycle.
- Empty with simultaneous push: no pop is possible, and count becomes 1.
- Push and pop in the same cycle with count ≥1: count is unchanged and the data ordering is preserved.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.
- out_flit, out_is_header, out_is_tail and out_port stay stable while out_valid && !out_ready.

## Structure
- Shared package/include (next to Noc_parameters.v):
  - port-index constants LOCAL/NORTH/SOUTH/EAST/WEST
  - header field offsets and widths
  - the XY route function
- Sub-module noc_flit_fifo: parameterised DEPTH × (Noc_Data_Width+2) FIFO providing push, pop, full, empty and count.
- noc_input_port owns route_reg, the packet state machine and err_framing.

## Test plan
- Single-flit packet: X_ID=1, Y_ID=1, push {hdr,tail} with dest (3,1) → out_valid one cycle later, out_port=5'b01000 (East), pop empties FIFO.
- 4-flit packet to (1,0) at router (1,1) → out_port=5'b00100 (South) on all four flits, including body/tail after the header pop; route_reg unchanged until the next header.
- Backpressure: DEPTH=4, out_ready=0, push 6 flits → in_ready drops after the 4th accepted. Release out_ready → flits emerge in order with no loss or duplication.
- Back-to-back packets: dests (0,1) then (1,1) at router (1,1) → out_port West for packet 1, Local for packet 2, switching exactly at the second header.
- Framing error: body flit pushed in IDLE → err_framing=1 the next cycle; the flit is still forwarded; the flag holds until reset.
- Reset mid-packet: after 2 of 4 flits buffered, assert noc_rst_n=0 for one edge → out_valid=0, in_ready=0 during reset, in_ready=1 after release, no stale flits emitted.
